// File: rtl/multiplicador_secuencial_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multiplicador_secuencial_param_if: request/result bundle of the multiplier.
// Rev 1.0
// ---------------------------------------------------------------------------
interface multiplicador_secuencial_param_if #(
  parameter int WIDTH = 8
);
  logic                 i_start;
  logic                 i_signed;
  logic [WIDTH-1:0]     i_multiplicando;
  logic [WIDTH-1:0]     i_multiplicador;
  logic [2*WIDTH-1:0]   o_producto;
  logic                 o_ready;
  logic                 o_busy;

  modport master (
    output i_start, i_signed, i_multiplicando, i_multiplicador,
    input  o_producto, o_ready, o_busy
  );

  modport slave (
    input  i_start, i_signed, i_multiplicando, i_multiplicador,
    output o_producto, o_ready, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/multiplicador_secuencial_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multiplicador_secuencial_param: shift-add WIDTH x WIDTH multiplier, one bit per cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
module multiplicador_secuencial_param #(
  parameter int WIDTH = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  multiplicador_secuencial_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_signed;
  logic [2*WIDTH-1:0]   r_producto;

  logic                 w_zero;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_zero = (bus.i_multiplicando == '0) || (bus.i_multiplicador == '0);
  assign w_last = (r_cnt == C_CNT_LAST);

  // The multiplier's MSB carries weight -2^(WIDTH-1) in signed mode, so its
  // partial product is subtracted instead of added; modular 2*WIDTH arithmetic
  // then yields the exact two's-complement product.
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = (w_last && r_signed) ? (r_acc - w_addend) : (r_acc + w_addend);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_next = w_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_signed   <= 1'b0;
      r_producto <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_mcand  <= {{WIDTH{bus.i_signed & bus.i_multiplicando[WIDTH-1]}},
                         bus.i_multiplicando};
            r_mplier <= bus.i_multiplicador;
            r_signed <= bus.i_signed;
            r_cnt    <= C_CNT_INIT;
            r_acc    <= '0;
            if (w_zero) begin
              r_producto <= '0;
            end
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - C_CNT_LAST;
          if (w_last) begin
            r_producto <= w_acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_producto = r_producto;
  assign bus.o_ready    = (r_state == S_DONE);
  assign bus.o_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_secuencial_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multiplicador_secuencial_param: randomized self-checking bench, WIDTH 8/4/16.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_multiplicador_secuencial_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multiplicador_secuencial_param_if #(.WIDTH(8))  bus8();
  multiplicador_secuencial_param_if #(.WIDTH(4))  bus4();
  multiplicador_secuencial_param_if #(.WIDTH(16)) bus16();

  multiplicador_secuencial_param #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  multiplicador_secuencial_param #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  multiplicador_secuencial_param #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Exact integer product of w-bit operands, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn, input int w);
    longint x, y, p, m;
    x = longint'(a);
    y = longint'(b);
    if (sgn && a[w-1]) x = x - (longint'(1) << w);
    if (sgn && b[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    m = (longint'(1) << (2 * w)) - 1;
    return 64'(p & m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one WIDTH=8 operation from IDLE and measures its observable behaviour.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sgn,
                     output int rdy_cyc, output int busy_cyc, output int pulses,
                     output logic [15:0] prod, output bit held);
    logic [15:0] prev;
    prev = bus8.o_producto;
    rdy_cyc = -1; busy_cyc = 0; pulses = 0; prod = '0; held = 1'b1;
    bus8.i_multiplicando = a;
    bus8.i_multiplicador = b;
    bus8.i_signed        = sgn;
    bus8.i_start         = 1'b1;
    tick();
    bus8.i_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus8.o_busy) busy_cyc++;
      if (bus8.o_ready) begin
        pulses++;
        if (rdy_cyc < 0) begin
          rdy_cyc = c;
          prod = bus8.o_producto;
        end
      end else if (rdy_cyc < 0 && bus8.o_producto !== prev) begin
        held = 1'b0;
      end
      if (c == 2) begin
        bus8.i_multiplicando = 8'($urandom);
        bus8.i_multiplicador = 8'($urandom);
        bus8.i_signed        = 1'($urandom);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.i_start = 1'b1;
    bus8.i_multiplicando = 8'hD7;
    bus8.i_multiplicador = 8'hDF;
    repeat (3) tick();
    n_checks++;
    if (bus8.o_producto !== 16'h0000) begin
      n_fail++; $display("FAIL reset_producto got %h want 0000", bus8.o_producto);
    end
    n_checks++;
    if (bus8.o_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b want 0", bus8.o_ready);
    end
    n_checks++;
    if (bus8.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0", bus8.o_busy);
    end
    n_checks++;
    if (bus16.o_producto !== 32'h0 || bus4.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_other got %h/%b want 0/0", bus16.o_producto, bus4.o_busy);
    end
    bus8.i_start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    logic [7:0] a, b;
    logic [15:0] exp, prod;
    int rc, bc, pc, lat;
    bit held;
    for (int i = 0; i < 12; i++) begin
      a = (i == 0) ? 8'hD7 : 8'($urandom);
      b = (i == 0) ? 8'hDF : 8'($urandom);
      exp = (i == 0) ? 16'hBB49 : 16'(ref_mul(32'(a), 32'(b), 1'b0, 8));
      lat = (a == 0 || b == 0) ? 1 : 9;
      op8(a, b, 1'b0, rc, bc, pc, prod, held);
      n_checks++;
      if (prod !== exp) begin
        n_fail++; $display("FAIL unsigned_prod %h*%h got %h want %h", a, b, prod, exp);
      end
      n_checks++;
      if (rc != lat || bc != lat || pc != 1) begin
        n_fail++; $display("FAIL unsigned_timing ready@%0d busy=%0d pulses=%0d want %0d/%0d/1", rc, bc, pc, lat, lat);
      end
      n_checks++;
      if (!held) begin
        n_fail++; $display("FAIL unsigned_hold producto changed before ready got 0 want 1");
      end
    end
  endtask

  task automatic test_signed();
    logic [7:0] a, b;
    logic [15:0] exp, prod;
    logic [7:0]  da [3] = '{8'hD7, 8'h80, 8'h80};
    logic [7:0]  db [3] = '{8'hDF, 8'h80, 8'h7F};
    logic [15:0] de [3] = '{16'h0549, 16'h4000, 16'hC080};
    int rc, bc, pc, lat;
    bit held;
    for (int i = 0; i < 13; i++) begin
      a = (i < 3) ? da[i] : 8'($urandom);
      b = (i < 3) ? db[i] : 8'($urandom);
      exp = (i < 3) ? de[i] : 16'(ref_mul(32'(a), 32'(b), 1'b1, 8));
      lat = (a == 0 || b == 0) ? 1 : 9;
      op8(a, b, 1'b1, rc, bc, pc, prod, held);
      n_checks++;
      if (prod !== exp) begin
        n_fail++; $display("FAIL signed_prod %h*%h got %h want %h", a, b, prod, exp);
      end
      n_checks++;
      if (rc != lat || bc != lat || pc != 1 || !held) begin
        n_fail++; $display("FAIL signed_timing ready@%0d busy=%0d pulses=%0d held=%0d want %0d/%0d/1/1", rc, bc, pc, held, lat, lat);
      end
    end
  endtask

  task automatic test_zero();
    logic [15:0] prod;
    int rc, bc, pc;
    bit held;
    op8(8'hD7, 8'hDF, 1'b0, rc, bc, pc, prod, held);
    op8(8'h00, 8'hFF, 1'b0, rc, bc, pc, prod, held);
    n_checks++;
    if (prod !== 16'h0000 || rc != 1 || bc != 1 || pc != 1) begin
      n_fail++; $display("FAIL zero_a prod=%h ready@%0d busy=%0d pulses=%0d want 0000/1/1/1", prod, rc, bc, pc);
    end
    op8(8'h5A, 8'h00, 1'b1, rc, bc, pc, prod, held);
    n_checks++;
    if (prod !== 16'h0000 || rc != 1 || bc != 1 || pc != 1) begin
      n_fail++; $display("FAIL zero_b prod=%h ready@%0d busy=%0d pulses=%0d want 0000/1/1/1", prod, rc, bc, pc);
    end
  endtask

  task automatic test_busy_protection();
    int pulses, rc, idle_bad;
    pulses = 0; rc = -1; idle_bad = 0;
    bus8.i_multiplicando = 8'hD7;
    bus8.i_multiplicador = 8'hDF;
    bus8.i_signed        = 1'b0;
    bus8.i_start         = 1'b1;
    tick();
    bus8.i_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (bus8.o_ready) begin
        pulses++;
        rc = c;
        n_checks++;
        if (bus8.o_producto !== 16'hBB49) begin
          n_fail++; $display("FAIL busy_prot_prod got %h want bb49", bus8.o_producto);
        end
      end
      if (c >= 10 && bus8.o_busy) idle_bad++;
      if (c == 3 || c == 9) begin
        bus8.i_start = 1'b1;
        bus8.i_multiplicando = 8'hFF;
        bus8.i_multiplicador = 8'hFF;
      end else begin
        bus8.i_start = 1'b0;
      end
      tick();
    end
    n_checks++;
    if (pulses != 1 || rc != 9 || idle_bad != 0) begin
      n_fail++; $display("FAIL busy_prot_seq pulses=%0d ready@%0d busy_after=%0d want 1/9/0", pulses, rc, idle_bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] prod;
    int rc, bc, pc, seen;
    bit held;
    seen = 0;
    bus8.i_multiplicando = 8'hD7;
    bus8.i_multiplicador = 8'hDF;
    bus8.i_signed        = 1'b0;
    bus8.i_start         = 1'b1;
    tick();
    bus8.i_start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus8.o_producto !== 16'h0000 || bus8.o_busy !== 1'b0 || bus8.o_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_state prod=%h busy=%b ready=%b want 0000/0/0", bus8.o_producto, bus8.o_busy, bus8.o_ready);
    end
    for (int c = 0; c < 12; c++) begin
      if (bus8.o_ready || bus8.o_busy) seen++;
      tick();
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_mid_abort activity_cycles=%0d want 0", seen);
    end
    op8(8'hC7, 8'h55, 1'b0, rc, bc, pc, prod, held);
    n_checks++;
    if (prod !== 16'h4213 || rc != 9) begin
      n_fail++; $display("FAIL reset_mid_restart prod=%h ready@%0d want 4213/9", prod, rc);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    bit         ps [3];
    logic [15:0] exp;
    int n;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      pa[i] = 8'($urandom_range(1, 255));
      pb[i] = 8'($urandom_range(1, 255));
      ps[i] = 1'($urandom);
    end
    bus8.i_multiplicando = pa[0];
    bus8.i_multiplicador = pb[0];
    bus8.i_signed        = ps[0];
    bus8.i_start         = 1'b1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      if (bus8.o_ready && n < 3) begin
        exp = 16'(ref_mul(32'(pa[n]), 32'(pb[n]), ps[n], 8));
        n_checks++;
        if (bus8.o_producto !== exp || c != 9 + 10 * n) begin
          n_fail++; $display("FAIL b2b_op%0d prod=%h ready@%0d want %h/%0d", n, bus8.o_producto, c, exp, 9 + 10 * n);
        end
        n++;
        if (n < 3) begin
          bus8.i_multiplicando = pa[n];
          bus8.i_multiplicador = pb[n];
          bus8.i_signed        = ps[n];
        end else begin
          bus8.i_start = 1'b0;
        end
      end
      tick();
    end
    bus8.i_start = 1'b0;
    n_checks++;
    if (n != 3) begin
      n_fail++; $display("FAIL b2b_count got %0d want 3", n);
    end
    repeat (12) tick();
  endtask

  task automatic test_sweep_w4();
    logic [3:0] a, b;
    logic [7:0] exp, prod;
    bit sgn;
    int rc, lat;
    for (int i = 0; i < 24; i++) begin
      a = 4'($urandom); b = 4'($urandom); sgn = 1'(i);
      exp = 8'(ref_mul(32'(a), 32'(b), sgn, 4));
      lat = (a == 0 || b == 0) ? 1 : 5;
      rc = -1; prod = '0;
      bus4.i_multiplicando = a; bus4.i_multiplicador = b;
      bus4.i_signed = sgn; bus4.i_start = 1'b1;
      tick();
      bus4.i_start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        if (bus4.o_ready && rc < 0) begin rc = c; prod = bus4.o_producto; end
        tick();
      end
      n_checks++;
      if (prod !== exp || rc != lat) begin
        n_fail++; $display("FAIL w4 %h*%h s=%0d prod=%h ready@%0d want %h/%0d", a, b, sgn, prod, rc, exp, lat);
      end
    end
  endtask

  task automatic test_sweep_w16();
    logic [15:0] a, b;
    logic [31:0] exp, prod;
    bit sgn;
    int rc, lat;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom); b = 16'($urandom); sgn = 1'(i);
      if (i == 2) begin a = 16'h8000; b = 16'h8000; end
      exp = 32'(ref_mul(32'(a), 32'(b), sgn, 16));
      lat = (a == 0 || b == 0) ? 1 : 17;
      rc = -1; prod = '0;
      bus16.i_multiplicando = a; bus16.i_multiplicador = b;
      bus16.i_signed = sgn; bus16.i_start = 1'b1;
      tick();
      bus16.i_start = 1'b0;
      for (int c = 1; c <= 24; c++) begin
        if (bus16.o_ready && rc < 0) begin rc = c; prod = bus16.o_producto; end
        tick();
      end
      n_checks++;
      if (prod !== exp || rc != lat) begin
        n_fail++; $display("FAIL w16 %h*%h s=%0d prod=%h ready@%0d want %h/%0d", a, b, sgn, prod, rc, exp, lat);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.i_start = 1'b0;  bus8.i_signed = 1'b0;  bus8.i_multiplicando = '0;  bus8.i_multiplicador = '0;
    bus4.i_start = 1'b0;  bus4.i_signed = 1'b0;  bus4.i_multiplicando = '0;  bus4.i_multiplicador = '0;
    bus16.i_start = 1'b0; bus16.i_signed = 1'b0; bus16.i_multiplicando = '0; bus16.i_multiplicador = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_busy_protection();
    test_reset_mid();
    test_back_to_back();
    test_sweep_w4();
    test_sweep_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiplicador_secuencial_param.md
MULTIPLICADOR_SECUENCIAL_PARAM -- requirements
Module: multiplicador_secuencial_param

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 Clock  input  1  single system clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset is synchronous and active-high.
REQ-004 Start  input  1  request to begin a multiplication; sampled on rising edge.
REQ-005 Signed  input  1  1 = operands are two's complement, 0 = unsigned; sampled with Start.
REQ-006 Multiplicando  input  WIDTH  first operand; sampled with Start.
REQ-007 Multiplicador  input  WIDTH  second operand; sampled with Start.
REQ-008 Producto  output  2*WIDTH  registered product.
REQ-009 Ready  output  1  one-cycle pulse: Producto has just been updated with a new result.
REQ-010 Busy  output  1  high while a multiplication is in progress or completing; Start is ignored while high.

Function
REQ-011 FSM states: IDLE, CALC, DONE; Busy SHALL equal (state != IDLE), Ready SHALL equal (state == DONE), both decoded from registered state.
REQ-012 IDLE, Start=1 at edge k: latch Multiplicando, Multiplicador, Signed into internal registers; load step counter with WIDTH; go to CALC.
REQ-013 IDLE, Start=1, either operand zero at edge k: go directly to DONE, Producto <= 0 (early-termination path, Ready high in cycle k+1).
REQ-014 CALC: exactly one multiplier bit processed per edge; counter decrements each edge; on the edge that processes the last bit (edge k+WIDTH), Producto <= final product and state <= DONE.
REQ-015 Latency: Ready high in the cycle after edge k+WIDTH for non-zero operands; it is fixed and data-independent, including for Signed=1.
REQ-016 DONE: unconditionally returns to IDLE on the next edge; Start in DONE is ignored (not queued).
REQ-017 Start in CALC or DONE SHALL be ignored, and changes on operand/Signed inputs while Busy=1 SHALL NOT affect the result.
REQ-018 Producto SHALL hold its previous value during CALC and until the next DONE update; it changes only on entry to DONE or on Reset.
REQ-019 Signed=0: Producto = exact unsigned product, width 2*WIDTH, no overflow possible.
REQ-020 Signed=1: Producto = exact two's-complement product in 2*WIDTH bits, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = +2^(2*WIDTH-2).
REQ-021 Start held high continuously SHALL start a new operation each time the FSM is back in IDLE (one edge after DONE).

Reset
REQ-022 Reset=1 at a rising edge: state <= IDLE, Producto <= 0, Ready = 0, Busy = 0, counter and internal operand/accumulator registers <= 0.
REQ-023 Reset has priority over Start and over all FSM transitions; Reset during CALC or DONE aborts the operation with no Ready pulse.
REQ-024 First Start accepted is the first edge with Reset=0 and Start=1.

Verification (WIDTH=8 unless stated)
REQ-025 Unsigned: Signed=0, 0xD7 x 0xDF, Start at edge k -> Busy high cycles k+1..k+9, Ready pulse only in cycle k+9, Producto=0xBB49.
REQ-026 Signed: Signed=1, 0xD7 x 0xDF (-41 x -33) -> Producto=0x0549; 0x80 x 0x80 -> 0x4000; 0x80 x 0x7F -> 0xC080; same 9-cycle timing.
REQ-027 Zero shortcut: 0x00 x 0xFF -> Ready in cycle k+1, Producto=0x0000, Busy high exactly 1 cycle.
REQ-028 Busy protection: Start 0xD7 x 0xDF, then Start=1 with 0xFF x 0xFF at k+3 and at DONE -> single Ready pulse, Producto=0xBB49, FSM back in IDLE.
REQ-029 Reset mid-operation: Start 0xD7 x 0xDF, Reset at k+4 -> Producto=0, Busy=0, no Ready; then Start 0xC7 x 0x55 -> Producto=0x4213 after 8 CALC edges.
REQ-030 Parameter sweep: WIDTH=4 and WIDTH=16, random operands both modes against reference model -> exact match, Ready exactly WIDTH edges after Start.
